// File: rtl/mem_responder.sv
// mem_responder: wait-state memory target with a tristate data bus and a preload side port
module mem_responder #(
    parameter int WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic       we,
    input  logic       mem_req,
    output logic       mem_ready,
    inout  wire  [7:0] data,
    input  logic       load_we,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_data,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic [7:0] rd_reg;
    logic       rd_op;
    logic [7:0] mem [256];
    logic       done;
    assign done = state == WAIT && mem_req && cnt == 4'd0;
    // transaction FSM; ready/busy registered with the state, read data captured on completion
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rd_reg    <= 8'h00;
            rd_op     <= 1'b0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mem_req) begin
                    state <= WAIT;
                    cnt   <= 4'(WAIT_STATES);
                    busy  <= 1'b1;
                end
                WAIT: if (!mem_req) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    state     <= READY;
                    mem_ready <= 1'b1;
                    rd_op     <= !we;
                    if (!we) rd_reg <= mem[addr];
                end
                READY: if (!mem_req) begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    // storage: CPU write on completion, otherwise side-port preload only while idle with no request
    always_ff @(posedge clk)
        if (!rst && done && we) mem[addr] <= data;
        else if (!rst && state == IDLE && !mem_req && load_we) mem[load_addr] <= load_data;
    assign data = (state == READY && rd_op) ? rd_reg : 8'bz;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of two responders (0 and 3 wait states)
module tb_mem_responder;
    localparam logic [7:0] REL = 8'hFF;
    logic       clk = 0, rst = 1, we = 0, tb_drv = 0;
    logic [7:0] addr = 0, load_addr = 0, load_data = 0, tb_dat = 0;
    logic [1:0] mem_req = 0, load_we = 0, mem_ready, busy;
    wire  [7:0] data;
    int         checks = 0, errors = 0;
    logic [7:0] model [2][256];
    logic [7:0] known [2][$];

    assign data = tb_drv ? tb_dat : 8'bz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (data[i]);
    end

    mem_responder #(.WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .mem_req(mem_req[0]),
        .mem_ready(mem_ready[0]), .data(data), .load_we(load_we[0]),
        .load_addr(load_addr), .load_data(load_data), .busy(busy[0])
    );
    mem_responder #(.WAIT_STATES(3)) u1 (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .mem_req(mem_req[1]),
        .mem_ready(mem_ready[1]), .data(data), .load_we(load_we[1]),
        .load_addr(load_addr), .load_data(load_data), .busy(busy[1])
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic do_load(input int d, input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        load_we[d] = 1; load_addr = a; load_data = v;
        @(negedge clk);
        load_we[d] = 0;
        model[d][a] = v;
        known[d].push_back(a);
    endtask

    task automatic txn(input int d, input logic [7:0] a, input logic w, input logic [7:0] v,
                       input int hold, input bit collide, input logic [7:0] cv);
        int k;
        bit bad;
        logic [7:0] exp;
        exp = model[d][a];
        bad = 0;
        @(negedge clk);
        addr = a; we = w; mem_req[d] = 1; tb_drv = w; tb_dat = v;
        if (collide) begin load_we[d] = 1; load_addr = a; load_data = cv; end
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            load_we[d] = 0;
            if (mem_ready[d] !== 1'b1 && (busy[d] !== 1'b1 || (!w && data !== REL))) bad = 1;
        end while (mem_ready[d] !== 1'b1 && k < 40);
        checks++;
        if (bad) begin errors++; $display("FAIL wait_phase dut%0d busy=%b data=%h", d, busy[d], data); end
        checks++;
        if (k != (d ? 5 : 2)) begin errors++; $display("FAIL latency dut%0d got %0d want %0d", d, k, d ? 5 : 2); end
        if (!w) begin
            checks++;
            if (data !== exp) begin errors++; $display("FAIL read_data dut%0d addr %h got %h want %h", d, a, data, exp); end
        end else begin
            model[d][a] = v;
            known[d].push_back(a);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            addr = 8'($urandom);
            tb_dat = ~v;
            @(posedge clk); #1;
            checks++;
            if (mem_ready[d] !== 1'b1 || busy[d] !== 1'b1 || (!w && data !== exp)) begin
                errors++;
                $display("FAIL hold dut%0d ready=%b busy=%b data=%h want 1 1 %h", d, mem_ready[d], busy[d], data, exp);
            end
        end
        if (w) begin
            @(negedge clk);
            tb_drv = 0;
            #1;
            checks++;
            if (data !== REL || mem_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL write_release dut%0d data=%h ready=%b want %h 1", d, data, mem_ready[d], REL);
            end
        end
        @(negedge clk);
        mem_req[d] = 0; tb_drv = 0;
        @(posedge clk); #1;
        checks++;
        if (mem_ready[d] !== 1'b0 || busy[d] !== 1'b0 || data !== REL) begin
            errors++;
            $display("FAIL drop dut%0d ready=%b busy=%b data=%h want 0 0 %h", d, mem_ready[d], busy[d], data, REL);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (mem_ready[d] !== 1'b0 || busy[d] !== 1'b0 || data !== REL) begin
                errors++;
                $display("FAIL reset dut%0d ready=%b busy=%b data=%h want 0 0 %h", d, mem_ready[d], busy[d], data, REL);
            end
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_preload_read;
        do_load(0, 8'hE0, 8'h01);
        txn(0, 8'hE0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_wait_states;
        txn(1, 8'hFF, 1, 8'h5A, 0, 0, 0);
        txn(1, 8'hFF, 0, 0, 0, 0, 0);
    endtask

    task automatic test_abort;
        bit bad;
        do_load(1, 8'h10, 8'h00);
        @(negedge clk);
        addr = 8'h10; we = 1; tb_drv = 1; tb_dat = 8'h77; mem_req[1] = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_req[1] = 0; tb_drv = 0;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (mem_ready[1] !== 1'b0) bad = 1;
        end
        checks++;
        if (bad || busy[1] !== 1'b0) begin errors++; $display("FAIL abort ready_seen=%b busy=%b want 0 0", bad, busy[1]); end
        txn(1, 8'h10, 0, 0, 0, 0, 0);
    endtask

    task automatic test_collision;
        do_load(0, 8'h20, 8'h11);
        txn(0, 8'h20, 0, 0, 0, 1, 8'hAA);
        txn(0, 8'h20, 0, 0, 1, 0, 0);
    endtask

    task automatic test_reset_ready;
        int k;
        do_load(0, 8'h40, 8'h3C);
        @(negedge clk);
        addr = 8'h40; we = 0; mem_req[0] = 1;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (mem_ready[0] !== 1'b1 && k < 40);
        checks++;
        if (data !== 8'h3C) begin errors++; $display("FAIL rst_ready_pre got %h want 3c", data); end
        #2 rst = 1;
        #1;
        checks++;
        if (mem_ready[0] !== 1'b0 || busy[0] !== 1'b0 || data !== REL) begin
            errors++;
            $display("FAIL rst_async ready=%b busy=%b data=%h want 0 0 %h", mem_ready[0], busy[0], data, REL);
        end
        @(negedge clk);
        rst = 0; mem_req[0] = 0;
        txn(0, 8'h40, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_wait;
        do_load(1, 8'h50, 8'h0F);
        @(negedge clk);
        addr = 8'h50; we = 1; tb_drv = 1; tb_dat = 8'hF0; mem_req[1] = 1;
        repeat (2) @(posedge clk);
        #2 rst = 1;
        #1;
        checks++;
        if (busy[1] !== 1'b0 || mem_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait busy=%b ready=%b want 0 0", busy[1], mem_ready[1]);
        end
        @(negedge clk);
        rst = 0; mem_req[1] = 0; tb_drv = 0;
        txn(1, 8'h50, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back_hold;
        txn(1, 8'h33, 1, 8'hC3, 10, 0, 0);
        txn(1, 8'h33, 0, 0, 2, 0, 0);
        txn(0, 8'h34, 1, 8'h3C, 10, 0, 0);
        txn(0, 8'h34, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random;
        int d, c;
        logic [7:0] a;
        for (int i = 0; i < 40; i++) begin
            d = $urandom_range(1, 0);
            c = $urandom_range(2, 0);
            if (c == 0) begin
                do_load(d, 8'($urandom), 8'($urandom));
            end else if (c == 1 || known[d].size() == 0) begin
                txn(d, 8'($urandom), 1, 8'($urandom), $urandom_range(3, 0), 0, 0);
            end else begin
                a = known[d][$urandom_range(known[d].size() - 1, 0)];
                txn(d, a, 0, 0, $urandom_range(3, 0), 0, 0);
            end
        end
    endtask

    // run all scenarios, then report
    initial begin
        test_reset;
        test_preload_read;
        test_wait_states;
        test_abort;
        test_collision;
        test_reset_ready;
        test_reset_wait;
        test_back_to_back_hold;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // hard stop if the run stalls
    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end
endmodule
